// File: rtl/sprite_blitter.sv
// Sprite compositor: box test and ROM addressing for the heart sprite, then a
// colour-key merge onto the background stream with a fixed 3-cycle latency.
module sprite_blitter #(
    parameter int          SPR_W      = 20,
    parameter int          SPR_H      = 18,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [11:0] KEY_RGB    = 12'hFFF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       frame_start,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic       sprite_en,
    input  logic [9:0] px_x,
    input  logic [9:0] px_y,
    input  logic       px_valid,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [3:0] bg_r,
    input  logic [3:0] bg_g,
    input  logic [3:0] bg_b,
    output logic [8:0] rom_addr,
    input  logic [7:0] rom_r,
    input  logic [7:0] rom_g,
    input  logic [7:0] rom_b,
    output logic [3:0] out_r,
    output logic [3:0] out_g,
    output logic [3:0] out_b,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       px_valid_out,
    output logic       sprite_hit
);

    localparam int BOX_W = SPR_W << SCALE_LOG2;
    localparam int BOX_H = SPR_H << SCALE_LOG2;

    logic [9:0]  sx_q, sx_d, sy_q, sy_d;
    logic        sen_q, sen_d;
    logic [8:0]  rom_addr_q, rom_addr_d;
    logic        hit1_q, hit1_d, hit2_q, hit2_d;
    logic [11:0] bg1_q, bg1_d, bg2_q, bg2_d;
    logic        hs1_q, hs1_d, hs2_q, hs2_d, hs3_q, hs3_d;
    logic        vs1_q, vs1_d, vs2_q, vs2_d, vs3_q, vs3_d;
    logic        vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
    logic [11:0] out_rgb_q, out_rgb_d;
    logic        hit3_q, hit3_d;

    logic [10:0] dx_s, dy_s;
    logic [9:0]  col_s, row_s;
    logic        in_box_s;
    logic [8:0]  addr_s;
    logic [11:0] tex_s;
    logic        opaque_s;
    logic        rom_unused_s;

    assign rom_unused_s = ^{rom_r[7:4], rom_g[7:4], rom_b[7:4]};

    // Box test and texel address; 11-bit differences keep off-screen positions from wrapping into the box
    always_comb begin
        dx_s     = {1'b0, px_x} - {1'b0, sx_q};
        dy_s     = {1'b0, px_y} - {1'b0, sy_q};
        col_s    = dx_s[9:0] >> SCALE_LOG2;
        row_s    = dy_s[9:0] >> SCALE_LOG2;
        in_box_s = sen_q && px_valid
                   && !dx_s[10] && (dx_s[9:0] < 10'(BOX_W))
                   && !dy_s[10] && (dy_s[9:0] < 10'(BOX_H));
        addr_s   = 9'(row_s * 10'(SPR_W) + col_s);
        tex_s    = {rom_r[3:0], rom_g[3:0], rom_b[3:0]};
        opaque_s = hit2_q && (tex_s != KEY_RGB);
    end

    // Next-state for shadow registers and the three pipeline stages
    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        sen_d = sen_q;
        if (frame_start) begin
            sx_d  = sprite_x;
            sy_d  = sprite_y;
            sen_d = sprite_en;
        end else begin
            sx_d  = sx_q;
        end

        rom_addr_d = in_box_s ? addr_s : 9'd0;
        hit1_d     = in_box_s;
        bg1_d      = {bg_r, bg_g, bg_b};
        hs1_d      = hsync_in;
        vs1_d      = vsync_in;
        vld1_d     = px_valid;

        hit2_d = hit1_q;
        bg2_d  = bg1_q;
        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        vld2_d = vld1_q;

        hs3_d  = hs2_q;
        vs3_d  = vs2_q;
        vld3_d = vld2_q;
        hit3_d = opaque_s && vld2_q;
        if (!vld2_q) begin
            out_rgb_d = 12'h000;
        end else if (opaque_s) begin
            out_rgb_d = tex_s;
        end else begin
            out_rgb_d = bg2_q;
        end
    end

    // State registers; reset flushes the whole pipeline immediately
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sx_q       <= 10'd0;
            sy_q       <= 10'd0;
            sen_q      <= 1'b0;
            rom_addr_q <= 9'd0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            hit3_q     <= 1'b0;
            bg1_q      <= 12'h000;
            bg2_q      <= 12'h000;
            hs1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            hs3_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            vs3_q      <= 1'b0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            vld3_q     <= 1'b0;
            out_rgb_q  <= 12'h000;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            sen_q      <= sen_d;
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            hit2_q     <= hit2_d;
            hit3_q     <= hit3_d;
            bg1_q      <= bg1_d;
            bg2_q      <= bg2_d;
            hs1_q      <= hs1_d;
            hs2_q      <= hs2_d;
            hs3_q      <= hs3_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            vs3_q      <= vs3_d;
            vld1_q     <= vld1_d;
            vld2_q     <= vld2_d;
            vld3_q     <= vld3_d;
            out_rgb_q  <= out_rgb_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign out_r        = out_rgb_q[11:8];
    assign out_g        = out_rgb_q[7:4];
    assign out_b        = out_rgb_q[3:0];
    assign hsync_out    = hs3_q;
    assign vsync_out    = vs3_q;
    assign px_valid_out = vld3_q;
    assign sprite_hit   = hit3_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a 1x and a 2x instance share the stimulus,
// each fed by its own registered-read sprite ROM.
module tb_sprite_blitter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       frame_start;
    logic [9:0] sprite_x, sprite_y;
    logic       sprite_en;
    logic [9:0] px_x, px_y;
    logic       px_valid, hsync_in, vsync_in;
    logic [3:0] bg_r, bg_g, bg_b;

    logic [8:0] rom_addr0, rom_addr1;
    logic [7:0] rom_r0, rom_g0, rom_b0, rom_r1, rom_g1, rom_b1;
    logic [3:0] out_r0, out_g0, out_b0, out_r1, out_g1, out_b1;
    logic       hs0, vs0, vo0, hit0, hs1, vs1, vo1, hit1;

    logic [11:0] rom0_q, rom1_q;
    logic [8:0]  a0_d1, a0_d2, a1_d1, a1_d2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [11:0] rgb0;
        logic        hit0;
        logic [8:0]  addr0;
        logic        chk2;
        logic [11:0] rgb1;
        logic        hit1;
        logic [8:0]  addr1;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    sprite_blitter #(.SCALE_LOG2(0)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .rom_addr(rom_addr0), .rom_r(rom_r0), .rom_g(rom_g0), .rom_b(rom_b0),
        .out_r(out_r0), .out_g(out_g0), .out_b(out_b0),
        .hsync_out(hs0), .vsync_out(vs0), .px_valid_out(vo0), .sprite_hit(hit0)
    );

    sprite_blitter #(.SCALE_LOG2(1)) dut2 (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_en(sprite_en),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .rom_addr(rom_addr1), .rom_r(rom_r1), .rom_g(rom_g1), .rom_b(rom_b1),
        .out_r(out_r1), .out_g(out_g1), .out_b(out_b1),
        .hsync_out(hs1), .vsync_out(vs1), .px_valid_out(vo1), .sprite_hit(hit1)
    );

    // Texel content: address 0 is the key colour, 210 is pure red, others derived from the address
    function automatic logic [11:0] tex(input logic [8:0] a);
        if (a == 9'd0)        return 12'hFFF;
        else if (a == 9'd210) return 12'hF00;
        else                  return {a[3:0], a[7:4], ~a[3:0]};
    endfunction

    // Sprite ROMs with junk upper nibble; address history aligns rom_addr with the output
    always @(posedge clock) begin
        rom0_q <= tex(rom_addr0);
        rom1_q <= tex(rom_addr1);
        a0_d1  <= rom_addr0;
        a0_d2  <= a0_d1;
        a1_d1  <= rom_addr1;
        a1_d2  <= a1_d1;
    end
    assign rom_r0 = {4'hA, rom0_q[11:8]};
    assign rom_g0 = {4'h5, rom0_q[7:4]};
    assign rom_b0 = {4'hC, rom0_q[3:0]};
    assign rom_r1 = {4'hA, rom1_q[11:8]};
    assign rom_g1 = {4'h5, rom1_q[7:4]};
    assign rom_b1 = {4'hC, rom1_q[3:0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid output pixel is matched against the oldest expectation
    always @(negedge clock) begin
        if (resetn === 1'b1 && vo0 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got valid output expected none at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("rgb0",  {20'd0, out_r0, out_g0, out_b0}, {20'd0, mon_e.rgb0});
                check("hit0",  {31'd0, hit0}, {31'd0, mon_e.hit0});
                check("addr0", {23'd0, a0_d2}, {23'd0, mon_e.addr0});
                check("hsync", {31'd0, hs0}, {31'd0, mon_e.hs});
                check("vsync", {31'd0, vs0}, {31'd0, mon_e.vs});
                if (mon_e.chk2) begin
                    check("rgb1",  {20'd0, out_r1, out_g1, out_b1}, {20'd0, mon_e.rgb1});
                    check("hit1",  {31'd0, hit1}, {31'd0, mon_e.hit1});
                    check("addr1", {23'd0, a1_d2}, {23'd0, mon_e.addr1});
                end
            end
        end
    end

    task automatic drive(input int x, input int y, input logic v, input logic fs);
        @(negedge clock);
        px_x        = 10'(x);
        px_y        = 10'(y);
        px_valid    = v;
        frame_start = fs;
        hsync_in    = px_x[1];
        vsync_in    = px_y[2];
        bg_r        = px_x[3:0] ^ 4'h3;
        bg_g        = px_y[3:0];
        bg_b        = 4'hA;
    endtask

    task automatic fstart(input int x, input int y, input logic en);
        sprite_x  = 10'(x);
        sprite_y  = 10'(y);
        sprite_en = en;
        drive(0, 0, 1'b0, 1'b1);
    endtask

    // Valid pixel with hand-computed texel addresses (a0 for 1x, a1 for 2x when c2 is set)
    task automatic pix(input logic fs, input int x, input int y, input logic in0, input int a0,
                       input logic c2, input logic in1, input int a1);
        exp_t        e;
        logic [11:0] t0, t1, bg;
        drive(x, y, 1'b1, fs);
        bg      = {bg_r, bg_g, bg_b};
        t0      = tex(9'(a0));
        t1      = tex(9'(a1));
        e.hit0  = in0 && (t0 != 12'hFFF);
        e.rgb0  = e.hit0 ? t0 : bg;
        e.addr0 = in0 ? 9'(a0) : 9'd0;
        e.chk2  = c2;
        e.hit1  = in1 && (t1 != 12'hFFF);
        e.rgb1  = e.hit1 ? t1 : bg;
        e.addr1 = in1 ? 9'(a1) : 9'd0;
        e.hs    = hsync_in;
        e.vs    = vsync_in;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        frame_start = 1'b0; sprite_x = 10'd0; sprite_y = 10'd0; sprite_en = 1'b0;
        px_x = 10'd0; px_y = 10'd0; px_valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        bg_r = 4'd0; bg_g = 4'd0; bg_b = 4'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rgb",  {20'd0, out_r0, out_g0, out_b0}, 32'd0);
        check("rst_addr", {23'd0, rom_addr0}, 32'd0);
        check("rst_ctl",  {28'd0, hs0, vs0, vo0, hit0}, 32'd0);
        @(posedge clock);
        #2 resetn = 1'b1;

        fstart(100, 50, 1'b1);
        pix(1'b0, 100, 50, 1'b1,   0, 1'b1, 1'b1,   0);
        pix(1'b0, 110, 60, 1'b1, 210, 1'b1, 1'b1, 105);
        pix(1'b0, 119, 67, 1'b1, 359, 1'b0, 1'b0,   0);
        pix(1'b0, 119, 50, 1'b1,  19, 1'b0, 1'b0,   0);
        pix(1'b0, 100, 67, 1'b1, 340, 1'b0, 1'b0,   0);
        pix(1'b0, 120, 50, 1'b0,   0, 1'b1, 1'b1,  10);
        pix(1'b0,  99, 50, 1'b0,   0, 1'b1, 1'b0,   0);
        pix(1'b0, 100, 68, 1'b0,   0, 1'b1, 1'b1, 180);
        pix(1'b0, 103, 51, 1'b1,  23, 1'b1, 1'b1,   1);
        pix(1'b0, 139, 85, 1'b0,   0, 1'b1, 1'b1, 359);
        pix(1'b0, 140, 50, 1'b0,   0, 1'b1, 1'b0,   0);
        pix(1'b0, 100, 86, 1'b0,   0, 1'b1, 1'b0,   0);

        // Invalid pixel inside the box: black output, sync still delayed by 3
        drive(110, 60, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("inv_rgb",   {20'd0, out_r0, out_g0, out_b0}, 32'd0);
        check("inv_hit",   {31'd0, hit0}, 32'd0);
        check("inv_hsync", {31'd0, hs0}, 32'd1);

        sprite_x = 10'd300;
        pix(1'b0, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        pix(1'b0, 310, 60, 1'b0,   0, 1'b0, 1'b0, 0);
        pix(1'b1, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        pix(1'b0, 110, 60, 1'b0,   0, 1'b0, 1'b0, 0);
        pix(1'b0, 310, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        fstart(300, 50, 1'b0);
        pix(1'b0, 310, 60, 1'b0,   0, 1'b1, 1'b0, 0);
        fstart(1015, 50, 1'b1);
        pix(1'b0,    2, 50, 1'b0, 0, 1'b1, 1'b0, 0);
        pix(1'b0, 1015, 50, 1'b1, 0, 1'b1, 1'b1, 0);
        pix(1'b0, 1023, 50, 1'b1, 8, 1'b1, 1'b1, 4);

        // Reset in the middle of a run of valid pixels
        fstart(100, 50, 1'b1);
        pix(1'b0, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        pix(1'b0, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        pix(1'b0, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        pix(1'b0, 110, 60, 1'b1, 210, 1'b0, 1'b0, 0);
        drive(110, 60, 1'b0, 1'b0);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_rgb",  {20'd0, out_r0, out_g0, out_b0}, 32'd0);
        check("mid_rst_ctl",  {28'd0, hs0, vs0, vo0, hit0}, 32'd0);
        check("mid_rst_addr", {23'd0, rom_addr0}, 32'd0);
        check("mid_rst_dut2", {16'd0, out_r1, out_g1, out_b1, hs1, vs1, vo1, hit1}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #2 resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("resume_early", {30'd0, hs0, vs0}, 32'd0);
        end
        @(negedge clock);
        check("resume_sync", {30'd0, hs0, vs0}, 32'd3);
        pix(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(0, 0, 1'b0, 1'b0);
        repeat (2) drive(0, 0, 1'b0, 1'b0);
        check("drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
